burst_lsu: RTL and testbench

BURST_LSU -- requirements
Module: burst_lsu

---
 rtl/burst_lsu.sv | 193 +++++++++++++++++++
 tb/tb_burst_lsu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_lsu.sv
`default_nettype none
// ============================================================================
// Module   : burst_lsu
// Purpose  : Burst load/store unit. Latches one LDR/STR command, issues up to
//            MAX_BURST single-word memory requests at consecutive addresses
//            using a valid/ready handshake, bounds each beat with a wait
//            timeout and collects read data into a packed output vector.
// Revision : 1.0 - initial release
// ============================================================================
module burst_lsu #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [2:0]                     core_state,
    input  logic                           decoded_mem_read_enable,
    input  logic                           decoded_mem_write_enable,
    input  logic [3:0]                     burst_len,
    input  logic [ADDR_BITS-1:0]           rs,
    input  logic [DATA_BITS-1:0]           rt,
    output logic                           mem_read_valid,
    output logic [ADDR_BITS-1:0]           mem_read_address,
    input  logic                           mem_read_ready,
    input  logic [DATA_BITS-1:0]           mem_read_data,
    output logic                           mem_write_valid,
    output logic [ADDR_BITS-1:0]           mem_write_address,
    output logic [DATA_BITS-1:0]           mem_write_data,
    input  logic                           mem_write_ready,
    output logic [1:0]                     lsu_state,
    output logic [DATA_BITS*MAX_BURST-1:0] lsu_out,
    output logic                           lsu_error,
    output logic [3:0]                     beat_count
);

    localparam logic [2:0] c_CORE_REQUEST = 3'b011;
    localparam logic [2:0] c_CORE_UPDATE  = 3'b110;
    localparam logic [4:0] c_MAX_BURST    = 5'(MAX_BURST);
    localparam logic [8:0] c_TIMEOUT      = 9'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'b00,
        ST_REQUESTING = 2'b01,
        ST_WAITING    = 2'b10,
        ST_DONE       = 2'b11
    } state_t;

    state_t                 r_state;
    logic                   r_rd_valid;
    logic [ADDR_BITS-1:0]   r_rd_addr;
    logic                   r_wr_valid;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [DATA_BITS-1:0]   r_wr_data;
    logic [DATA_BITS-1:0]   r_words [MAX_BURST];
    logic                   r_error;
    logic [3:0]             r_beat_count;
    logic [7:0]             r_wait_cnt;
    logic [ADDR_BITS-1:0]   r_base;
    logic [4:0]             r_len;
    logic [DATA_BITS-1:0]   r_wdata;
    logic                   r_is_write;

    logic                   w_req_cmd;
    logic                   w_one_op;
    logic                   w_both_ops;
    logic [4:0]             w_len_clamped;
    logic [ADDR_BITS-1:0]   w_beat_addr;
    logic                   w_ready;
    logic                   w_last_beat;
    logic [8:0]             w_wait_next;
    logic                   w_timeout;

    assign w_req_cmd   = (core_state == c_CORE_REQUEST);
    assign w_one_op    = decoded_mem_read_enable ^ decoded_mem_write_enable;
    assign w_both_ops  = decoded_mem_read_enable & decoded_mem_write_enable;

    // A zero length still moves one word; anything past the buffer size is cut back.
    assign w_len_clamped = (burst_len == 4'd0) ? 5'd1 :
                           (({1'b0, burst_len} > c_MAX_BURST) ? c_MAX_BURST : {1'b0, burst_len});

    // Address arithmetic wraps naturally at the address width.
    assign w_beat_addr = r_base + ADDR_BITS'(r_beat_count);

    // Only the channel that belongs to the latched op can complete a beat.
    assign w_ready     = r_is_write ? mem_write_ready : mem_read_ready;
    assign w_last_beat = (({1'b0, r_beat_count} + 5'd1) == r_len);
    assign w_wait_next = {1'b0, r_wait_cnt} + 9'd1;
    assign w_timeout   = (w_wait_next == c_TIMEOUT);

    // Command latch, beat sequencing, handshake outputs and read-data capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_rd_valid   <= 1'b0;
            r_rd_addr    <= '0;
            r_wr_valid   <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_error      <= 1'b0;
            r_beat_count <= 4'd0;
            r_wait_cnt   <= 8'd0;
            r_base       <= '0;
            r_len        <= 5'd0;
            r_wdata      <= '0;
            r_is_write   <= 1'b0;
            for (int k = 0; k < MAX_BURST; k++) begin
                r_words[k] <= '0;
            end
        end else if (enable) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_cmd && w_one_op) begin
                        r_base       <= rs;
                        r_len        <= w_len_clamped;
                        r_wdata      <= rt;
                        r_is_write   <= decoded_mem_write_enable;
                        r_beat_count <= 4'd0;
                        r_error      <= 1'b0;
                        r_state      <= ST_REQUESTING;
                    end else if (w_req_cmd && w_both_ops) begin
                        r_error <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_REQUESTING: begin
                    if (r_is_write) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= w_beat_addr;
                        r_wr_data  <= r_wdata;
                    end else begin
                        r_rd_valid <= 1'b1;
                        r_rd_addr  <= w_beat_addr;
                    end
                    r_wait_cnt <= 8'd0;
                    r_state    <= ST_WAITING;
                end

                ST_WAITING: begin
                    // Ready wins over timeout when both happen on the same cycle.
                    if (w_ready) begin
                        r_rd_valid <= 1'b0;
                        r_wr_valid <= 1'b0;
                        if (!r_is_write) begin
                            for (int k = 0; k < MAX_BURST; k++) begin
                                if (r_beat_count == 4'(k)) begin
                                    r_words[k] <= mem_read_data;
                                end
                            end
                        end
                        r_beat_count <= r_beat_count + 4'd1;
                        r_state      <= w_last_beat ? ST_DONE : ST_REQUESTING;
                    end else if (w_timeout) begin
                        r_rd_valid <= 1'b0;
                        r_wr_valid <= 1'b0;
                        r_error    <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_wait_cnt <= w_wait_next[7:0];
                    end
                end

                ST_DONE: begin
                    if (core_state == c_CORE_UPDATE) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_read_valid    = r_rd_valid;
    assign mem_read_address  = r_rd_addr;
    assign mem_write_valid   = r_wr_valid;
    assign mem_write_address = r_wr_addr;
    assign mem_write_data    = r_wr_data;
    assign lsu_state         = r_state;
    assign lsu_error         = r_error;
    assign beat_count        = r_beat_count;

    generate
        for (genvar k = 0; k < MAX_BURST; k++) begin : g_pack
            assign lsu_out[k*DATA_BITS +: DATA_BITS] = r_words[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_burst_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_lsu
// Purpose  : Self-checking bench for burst_lsu (8-bit data/address,
//            MAX_BURST=4, TIMEOUT=4): directed vector table, a stall/reset
//            sequence, and randomized instructions against a memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_burst_lsu;

    localparam int         c_MAXB    = 4;
    localparam int         c_TO      = 4;
    localparam logic [2:0] c_REQUEST = 3'b011;
    localparam logic [2:0] c_UPDATE  = 3'b110;
    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_REQ     = 2'b01;
    localparam logic [1:0] c_WAIT    = 2'b10;
    localparam logic [1:0] c_DONE    = 2'b11;

    logic        clk = 1'b0;
    logic        reset, enable;
    logic [2:0]  core_state;
    logic        rd_en, wr_en;
    logic [3:0]  burst_len;
    logic [7:0]  rs, rt;
    logic        mem_read_valid, mem_read_ready;
    logic [7:0]  mem_read_address, mem_read_data;
    logic        mem_write_valid, mem_write_ready;
    logic [7:0]  mem_write_address, mem_write_data;
    logic [1:0]  lsu_state;
    logic [31:0] lsu_out;
    logic        lsu_error;
    logic [3:0]  beat_count;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flat memory plus the architectural result registers.
    logic [7:0] mem [256];
    logic [7:0] m_words [c_MAXB];
    int         m_beats;
    logic       m_err;
    int         lat_plan [16];

    typedef struct {
        logic        ld;
        logic        st;
        logic [7:0]  base;
        logic [7:0]  data;
        logic [3:0]  bl;
        int          lat;
        int          exp_beats;
        logic        exp_err;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs [10];

    burst_lsu #(.DATA_BITS(8), .ADDR_BITS(8), .MAX_BURST(c_MAXB), .TIMEOUT(c_TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .core_state               (core_state),
        .decoded_mem_read_enable  (rd_en),
        .decoded_mem_write_enable (wr_en),
        .burst_len                (burst_len),
        .rs                       (rs),
        .rt                       (rt),
        .mem_read_valid           (mem_read_valid),
        .mem_read_address         (mem_read_address),
        .mem_read_ready           (mem_read_ready),
        .mem_read_data            (mem_read_data),
        .mem_write_valid          (mem_write_valid),
        .mem_write_address        (mem_write_address),
        .mem_write_data           (mem_write_data),
        .mem_write_ready          (mem_write_ready),
        .lsu_state                (lsu_state),
        .lsu_out                  (lsu_out),
        .lsu_error                (lsu_error),
        .beat_count               (beat_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_out();
        return {m_words[3], m_words[2], m_words[1], m_words[0]};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, 32'(lsu_state), 32'(c_IDLE));
        chk({tag, "_rvalid"}, 32'(mem_read_valid), 32'd0);
        chk({tag, "_raddr"}, 32'(mem_read_address), 32'd0);
        chk({tag, "_wvalid"}, 32'(mem_write_valid), 32'd0);
        chk({tag, "_waddr"}, 32'(mem_write_address), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_write_data), 32'd0);
        chk({tag, "_out"}, lsu_out, 32'd0);
        chk({tag, "_err"}, 32'(lsu_error), 32'd0);
        chk({tag, "_beats"}, 32'(beat_count), 32'd0);
    endtask

    // Issue one instruction and follow it beat by beat until DONE, using
    // lat_plan[b] as the WAITING cycle on which beat b sees ready
    // (c_TO or more means ready never comes).
    task automatic run_instr(input logic ld, input logic st, input logic [7:0] base,
                             input logic [7:0] data, input logic [3:0] bl);
        int         len;
        logic [7:0] a;
        int         w;
        bit         beat_end;
        len = (bl == 4'd0) ? 1 : ((int'(bl) > c_MAXB) ? c_MAXB : int'(bl));
        chk("start_idle", 32'(lsu_state), 32'(c_IDLE));
        enable = 1'b1; core_state = c_REQUEST; rd_en = ld; wr_en = st;
        rs = base; rt = data; burst_len = bl;
        mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
        tick();
        // Command inputs are scrambled after the latch; they must not matter.
        core_state = 3'b000; rd_en = 1'($urandom); wr_en = 1'($urandom);
        rs = 8'($urandom); rt = 8'($urandom); burst_len = 4'($urandom);
        if (ld && st) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
            m_beats = 0;
            for (int b = 0; b < len && !m_err; b++) begin
                chk("req_state", 32'(lsu_state), 32'(c_REQ));
                chk("req_rvalid", 32'(mem_read_valid), 32'd0);
                chk("req_wvalid", 32'(mem_write_valid), 32'd0);
                chk("req_beats", 32'(beat_count), 32'(b));
                mem_read_ready = 1'($urandom); mem_write_ready = 1'($urandom);
                mem_read_data = 8'($urandom);
                tick();
                a = base + 8'(b);
                w = 0;
                beat_end = 1'b0;
                while (!beat_end) begin
                    chk("wait_state", 32'(lsu_state), 32'(c_WAIT));
                    chk("wait_rvalid", 32'(mem_read_valid), 32'(!st));
                    chk("wait_wvalid", 32'(mem_write_valid), 32'(st));
                    chk("wait_addr", 32'(st ? mem_write_address : mem_read_address), 32'(a));
                    if (st) chk("wait_wdata", 32'(mem_write_data), 32'(data));
                    if ($urandom_range(0, 7) == 0) begin
                        enable = 1'b0; mem_read_ready = 1'b1; mem_write_ready = 1'b1;
                        tick();
                        chk("stall_state", 32'(lsu_state), 32'(c_WAIT));
                        chk("stall_valid", 32'(st ? mem_write_valid : mem_read_valid), 32'd1);
                        chk("stall_beats", 32'(beat_count), 32'(b));
                        enable = 1'b1;
                    end
                    if (st) begin
                        mem_write_ready = (w == lat_plan[b]); mem_read_ready = 1'($urandom);
                    end else begin
                        mem_read_ready = (w == lat_plan[b]); mem_write_ready = 1'($urandom);
                    end
                    mem_read_data = (w == lat_plan[b]) ? mem[a] : 8'($urandom);
                    tick();
                    if (w == lat_plan[b]) begin
                        if (st) mem[a] = data;
                        else    m_words[b] = mem[a];
                        m_beats++;
                        beat_end = 1'b1;
                    end else if (w == c_TO - 1) begin
                        m_err = 1'b1;
                        beat_end = 1'b1;
                    end
                    w++;
                end
            end
        end
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        chk("done_state", 32'(lsu_state), 32'(c_DONE));
        chk("done_rvalid", 32'(mem_read_valid), 32'd0);
        chk("done_wvalid", 32'(mem_write_valid), 32'd0);
        chk("done_err", 32'(lsu_error), 32'(m_err));
        chk("done_beats", 32'(beat_count), 32'(m_beats));
        chk("done_out", lsu_out, m_out());
    endtask

    // Linger in DONE with a fresh command present, then retire on UPDATE.
    task automatic finish_instr();
        core_state = c_REQUEST; rd_en = 1'b1; wr_en = 1'($urandom);
        mem_read_ready = 1'b1; mem_write_ready = 1'b1;
        tick();
        chk("hold_state", 32'(lsu_state), 32'(c_DONE));
        chk("hold_out", lsu_out, m_out());
        chk("hold_rvalid", 32'(mem_read_valid), 32'd0);
        core_state = c_UPDATE; rd_en = 1'b0; wr_en = 1'b0;
        tick();
        chk("update_idle", 32'(lsu_state), 32'(c_IDLE));
        core_state = 3'b000; mem_read_ready = 1'b0; mem_write_ready = 1'b0;
    endtask

    initial begin
        // memory returns A0+addr until something is written there
        for (int i = 0; i < 256; i++) mem[i] = 8'(8'hA0 + i);
        for (int i = 0; i < c_MAXB; i++) m_words[i] = 8'h00;
        m_beats = 0; m_err = 1'b0;

        //                 ld    st    base   data   bl     lat beats err   out
        vecs[0] = '{1'b1, 1'b0, 8'h10, 8'h00, 4'd3,  2, 3, 1'b0, 32'h00B2B1B0};
        vecs[1] = '{1'b0, 1'b1, 8'hFE, 8'h5C, 4'd3,  1, 3, 1'b0, 32'h00B2B1B0};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 4'd2,  0, 2, 1'b0, 32'h00B25C5C};
        vecs[3] = '{1'b1, 1'b0, 8'h20, 8'h00, 4'd0,  3, 1, 1'b0, 32'h00B25CC0};
        vecs[4] = '{1'b1, 1'b0, 8'h30, 8'h00, 4'd9,  1, 4, 1'b0, 32'hD3D2D1D0};
        vecs[5] = '{1'b1, 1'b0, 8'h40, 8'h00, 4'd2,  4, 0, 1'b1, 32'hD3D2D1D0};
        vecs[6] = '{1'b1, 1'b1, 8'h50, 8'h77, 4'd2,  0, 0, 1'b1, 32'hD3D2D1D0};
        vecs[7] = '{1'b0, 1'b1, 8'h60, 8'hAA, 4'd15, 0, 4, 1'b0, 32'hD3D2D1D0};
        vecs[8] = '{1'b1, 1'b0, 8'h60, 8'h00, 4'd1,  3, 1, 1'b0, 32'hD3D2D1AA};
        vecs[9] = '{1'b1, 1'b0, 8'hF0, 8'h00, 4'd4,  0, 4, 1'b0, 32'h93929190};

        // reset dominates even with enable low
        reset = 1'b1; enable = 1'b0; core_state = c_REQUEST; rd_en = 1'b1; wr_en = 1'b0;
        burst_len = 4'd2; rs = 8'h33; rt = 8'h44;
        mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_read_data = 8'hEE;
        tick(); tick();
        chk_all_zero("reset");
        reset = 1'b0; enable = 1'b1; core_state = 3'b000; rd_en = 1'b0;
        mem_read_ready = 1'b0; mem_write_ready = 1'b0;
        tick();
        chk("post_reset_idle", 32'(lsu_state), 32'(c_IDLE));

        // directed vector table
        for (int v = 0; v < 10; v++) begin
            for (int b = 0; b < 16; b++) lat_plan[b] = vecs[v].lat;
            run_instr(vecs[v].ld, vecs[v].st, vecs[v].base, vecs[v].data, vecs[v].bl);
            chk($sformatf("vec%0d_beats", v), 32'(beat_count), 32'(vecs[v].exp_beats));
            chk($sformatf("vec%0d_err", v), 32'(lsu_error), 32'(vecs[v].exp_err));
            chk($sformatf("vec%0d_out", v), lsu_out, vecs[v].exp_out);
            finish_instr();
        end

        // freeze during WAITING of the second beat, then reset mid-burst
        core_state = c_REQUEST; rd_en = 1'b1; wr_en = 1'b0; rs = 8'h80; burst_len = 4'd3;
        tick();
        core_state = 3'b000; rd_en = 1'b0;
        tick();
        mem_read_ready = 1'b1; mem_read_data = mem[8'h80];
        tick();
        mem_read_ready = 1'b0;
        chk("stallseq_req", 32'(lsu_state), 32'(c_REQ));
        chk("stallseq_beats", 32'(beat_count), 32'd1);
        tick();
        chk("stallseq_wait", 32'(lsu_state), 32'(c_WAIT));
        chk("stallseq_addr", 32'(mem_read_address), 32'h81);
        enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 8'h11;
        repeat (5) begin
            tick();
            chk("frozen_state", 32'(lsu_state), 32'(c_WAIT));
            chk("frozen_valid", 32'(mem_read_valid), 32'd1);
            chk("frozen_addr", 32'(mem_read_address), 32'h81);
            chk("frozen_beats", 32'(beat_count), 32'd1);
        end
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0; enable = 1'b1;
        tick();
        chk("after_reset_idle", 32'(lsu_state), 32'(c_IDLE));
        chk("after_reset_rvalid", 32'(mem_read_valid), 32'd0);
        mem_read_ready = 1'b0;
        for (int i = 0; i < c_MAXB; i++) m_words[i] = 8'h00;
        m_beats = 0; m_err = 1'b0;

        // randomized instructions against the model
        for (int n = 0; n < 40; n++) begin
            int   r;
            logic ld, st;
            r  = int'($urandom_range(0, 9));
            ld = (r < 5) || (r == 9);
            st = (r >= 5);
            for (int b = 0; b < 16; b++)
                lat_plan[b] = ($urandom_range(0, 9) == 0) ? c_TO : int'($urandom_range(0, c_TO - 1));
            run_instr(ld, st, 8'($urandom), 8'($urandom), 4'($urandom));
            finish_instr();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
